// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
// Glyphs are {A,B,C,D,E,F,G}, 1 = lit.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// Hex nibble to seven-segment glyph, purely combinational.
// Feeds the output register stage in ssd_mux.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segs
);

  always_comb begin
    o_segs = SEG_BLANK;
    unique case (i_nibble)
      4'h0: o_segs = SEG_0;
      4'h1: o_segs = SEG_1;
      4'h2: o_segs = SEG_2;
      4'h3: o_segs = SEG_3;
      4'h4: o_segs = SEG_4;
      4'h5: o_segs = SEG_5;
      4'h6: o_segs = SEG_6;
      4'h7: o_segs = SEG_7;
      4'h8: o_segs = SEG_8;
      4'h9: o_segs = SEG_9;
      4'hA: o_segs = SEG_A;
      4'hB: o_segs = SEG_B;
      4'hC: o_segs = SEG_C;
      4'hD: o_segs = SEG_D;
      4'hE: o_segs = SEG_E;
      4'hF: o_segs = SEG_F;
    endcase
  end

endmodule

// File: rtl/ssd_mux.sv
// Time-multiplexed N-digit seven-segment driver with guard time,
// PWM brightness, decimal points and leading-zero blanking.
module ssd_mux
  import ssd_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int DIGIT_CYCLES = 1000,
  parameter int GUARD_CYCLES = 8,
  parameter int BR_W         = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [BR_W-1:0]       brightness,
  output logic [6:0]            ssd_segs,
  output logic                  ssd_dp,
  output logic [DIGITS-1:0]     ssd_sel,
  output logic                  frame_tick
);

  localparam int SLOT_W = clog2_min1(DIGIT_CYCLES);
  localparam int IDX_W  = clog2_min1(DIGITS);
  localparam int NSLOT  = 1 << IDX_W;

  localparam logic [SLOT_W-1:0] SLOT_LAST =
    SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(DIGITS - 1);
  localparam logic [BR_W-1:0] BR_FULL = '1;

  logic [SLOT_W-1:0]   r_slot_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [BR_W-1:0]     r_pwm_cnt;

  logic [4*DIGITS-1:0] r_snap_val;
  logic [DIGITS-1:0]   r_snap_dp;
  logic                r_snap_blz;
  logic [BR_W-1:0]     r_snap_br;

  logic [6:0]          r_segs;
  logic                r_dp;
  logic [DIGITS-1:0]   r_sel;
  logic                r_frame_tick;

  logic                w_frame_start;
  logic [4*DIGITS-1:0] w_val;
  logic [DIGITS-1:0]   w_dp;
  logic                w_blz;
  logic [BR_W-1:0]     w_br;

  logic [3:0]          w_nib [NSLOT];
  logic [NSLOT-1:0]    w_dp_pad;
  logic [NSLOT-1:0]    w_upper_zero;
  logic                w_run_zero;

  logic [3:0]          w_nib_sel;
  logic [6:0]          w_glyph;
  logic                w_guard;
  logic                w_lit;
  logic                w_on;
  logic                w_blank;
  logic [6:0]          w_segs_nxt;
  logic                w_dp_nxt;
  logic [DIGITS-1:0]   w_sel_nxt;

  assign w_frame_start = (r_slot_cnt == '0) && (r_idx == '0);

  // Frame-start cycle shows the inputs being captured, so the
  // whole frame is coherent with its own snapshot.
  assign w_val = w_frame_start ? value      : r_snap_val;
  assign w_dp  = w_frame_start ? dp_in      : r_snap_dp;
  assign w_blz = w_frame_start ? blank_lz   : r_snap_blz;
  assign w_br  = w_frame_start ? brightness : r_snap_br;

  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      w_nib[i]    = 4'h0;
      w_dp_pad[i] = 1'b0;
    end
    for (int i = 0; i < DIGITS; i++) begin
      w_nib[i]    = w_val[4*i +: 4];
      w_dp_pad[i] = w_dp[i];
    end
    w_upper_zero = '0;
    w_run_zero   = 1'b1;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      w_run_zero      = w_run_zero & (w_nib[i] == 4'h0);
      w_upper_zero[i] = w_run_zero;
    end
  end

  assign w_nib_sel = w_nib[r_idx];

  ssd_seg_decode u_dec (
    .i_nibble (w_nib_sel),
    .o_segs   (w_glyph)
  );

  generate
    if (GUARD_CYCLES == 0) begin : g_noguard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = r_slot_cnt < SLOT_W'(GUARD_CYCLES);
    end
  endgenerate

  assign w_lit   = (w_br == BR_FULL) || (r_pwm_cnt < w_br);
  assign w_on    = !w_guard && w_lit;
  assign w_blank = w_blz && (r_idx != '0) && w_upper_zero[r_idx];

  assign w_segs_nxt = (w_on && !w_blank) ? w_glyph : SEG_BLANK;
  assign w_dp_nxt   = w_on && w_dp_pad[r_idx];

  always_comb begin
    w_sel_nxt = '0;
    for (int i = 0; i < DIGITS; i++)
      w_sel_nxt[i] = (r_idx == IDX_W'(i));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_slot_cnt   <= '0;
      r_idx        <= '0;
      r_pwm_cnt    <= '0;
      r_snap_val   <= '0;
      r_snap_dp    <= '0;
      r_snap_blz   <= 1'b0;
      r_snap_br    <= '0;
      r_segs       <= SEG_BLANK;
      r_dp         <= 1'b0;
      r_sel        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_segs       <= w_segs_nxt;
      r_dp         <= w_dp_nxt;
      r_sel        <= w_sel_nxt;
      r_frame_tick <= w_frame_start;
      r_pwm_cnt    <= r_pwm_cnt + BR_W'(1);
      if (w_frame_start) begin
        r_snap_val <= value;
        r_snap_dp  <= dp_in;
        r_snap_blz <= blank_lz;
        r_snap_br  <= brightness;
      end
      if (r_slot_cnt == SLOT_LAST) begin
        r_slot_cnt <= '0;
        r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
      end
    end
  end

  assign ssd_segs   = r_segs;
  assign ssd_dp     = r_dp;
  assign ssd_sel    = r_sel;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_ssd_mux.sv
// Bench for ssd_mux: cycle scoreboard on a 2-digit instance,
// vector table for leading-zero blanking on a 4-digit instance.
module tb_ssd_mux;

  localparam logic [6:0] GLY [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic clk = 1'b0;
  logic resetn;

  logic [7:0]  value2;
  logic [1:0]  dpi2;
  logic        blz2;
  logic [3:0]  br2;
  logic [6:0]  segs2;
  logic        dp2;
  logic [1:0]  sel2;
  logic        ft2;

  logic [15:0] value4;
  logic [3:0]  dpi4;
  logic        blz4;
  logic [3:0]  br4;
  logic [6:0]  segs4;
  logic        dp4;
  logic [3:0]  sel4;
  logic        ft4;

  always #5 clk = ~clk;

  ssd_mux #(
    .DIGITS(2), .DIGIT_CYCLES(20),
    .GUARD_CYCLES(2), .BR_W(4)
  ) u_dut2 (
    .clk(clk), .resetn(resetn),
    .value(value2), .dp_in(dpi2),
    .blank_lz(blz2), .brightness(br2),
    .ssd_segs(segs2), .ssd_dp(dp2),
    .ssd_sel(sel2), .frame_tick(ft2)
  );

  ssd_mux #(
    .DIGITS(4), .DIGIT_CYCLES(20),
    .GUARD_CYCLES(2), .BR_W(4)
  ) u_dut4 (
    .clk(clk), .resetn(resetn),
    .value(value4), .dp_in(dpi4),
    .blank_lz(blz4), .brightness(br4),
    .ssd_segs(segs4), .ssd_dp(dp4),
    .ssd_sel(sel4), .frame_tick(ft4)
  );

  typedef struct packed {
    logic [6:0] segs;
    logic       dp;
    logic [1:0] sel;
    logic       ft;
  } exp_t;

  typedef struct packed {
    logic [15:0] val;
    logic        blz;
    logic [3:0]  dp;
    logic [27:0] segs;
  } vec_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   t = 0;

  logic [7:0] s_val;
  logic [1:0] s_dp;
  logic       s_blz;
  logic [3:0] s_br;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Expected output for the 2-digit DUT from the absolute
  // cycle count since the last reset release.
  task automatic step();
    exp_t e;
    exp_t g;
    int slot, d;
    logic [3:0] nib;
    logic lit, guard, blank;
    logic rst_now;
    rst_now = resetn;
    e = '0;
    if (rst_now) begin
      if (t % 40 == 0) begin
        s_val = value2;
        s_dp  = dpi2;
        s_blz = blz2;
        s_br  = br2;
      end
      slot  = t % 20;
      d     = (t / 20) % 2;
      nib   = s_val[4*d +: 4];
      lit   = (s_br == 4'hF) || ((t % 16) < int'(s_br));
      guard = slot < 2;
      blank = s_blz && d == 1 && nib == 4'h0;
      e.segs = (guard || !lit || blank) ? 7'b0 : GLY[nib];
      e.dp   = !guard && lit && s_dp[d];
      e.sel  = (d == 0) ? 2'b01 : 2'b10;
      e.ft   = (t % 40 == 0);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    t = rst_now ? t + 1 : 0;
    g = {segs2, dp2, sel2, ft2};
    e = sb_q.pop_front();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL scan t=%0d got seg=%b dp=%b sel=%b ft=%b want seg=%b dp=%b sel=%b ft=%b",
               t, g.segs, g.dp, g.sel, g.ft,
               e.segs, e.dp, e.sel, e.ft);
    end
  endtask

  task automatic to_phase(int ph);
    while (t % 40 != ph) step();
  endtask

  vec_t vecs [7];

  initial begin
    int n, lit, dpa, dpb;
    vecs[0] = '{16'h0050, 1'b1, 4'b0000,
      {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}};
    vecs[1] = '{16'h0050, 1'b0, 4'b0000,
      {7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110}};
    vecs[2] = '{16'h0000, 1'b1, 4'b0100,
      {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
    vecs[3] = '{16'h00C7, 1'b1, 4'b0000,
      {7'b0000000, 7'b0000000, 7'b1001110, 7'b1110000}};
    vecs[4] = '{16'h1000, 1'b1, 4'b0000,
      {7'b0110000, 7'b1111110, 7'b1111110, 7'b1111110}};
    vecs[5] = '{16'h0E0F, 1'b1, 4'b0010,
      {7'b0000000, 7'b1001111, 7'b1111110, 7'b1000111}};
    vecs[6] = '{16'hBD96, 1'b1, 4'b1001,
      {7'b0011111, 7'b0111101, 7'b1111011, 7'b1011111}};

    resetn = 1'b0;
    value2 = 8'hFF; dpi2 = 2'b11; blz2 = 1'b0; br2 = 4'hF;
    value4 = 16'hFFFF; dpi4 = '0; blz4 = 1'b0; br4 = 4'hF;
    s_val = '0; s_dp = '0; s_blz = 1'b0; s_br = '0;

    repeat (5) step();
    chk("rst_segs", segs2, 0);

    resetn = 1'b1;
    value2 = 8'h3A; dpi2 = 2'b00;
    step();
    chk("rel_tick", ft2, 1);
    chk("rel_sel", sel2, 1);

    n = 0;
    do begin step(); n++; end while (!ft2 && n < 100);
    chk("frame_period", n, 40);

    to_phase(25);
    value2 = 8'h12;
    to_phase(31);
    chk("snap_hold_d1", segs2, 7'b1111001);
    to_phase(6);
    chk("next_d0", segs2, 7'b1101101);
    to_phase(26);
    chk("next_d1", segs2, 7'b0110000);

    value2 = 8'h88; br2 = 4'h0;
    to_phase(0);
    lit = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (segs2 != 0) lit++;
    end
    chk("br0_lit", lit, 0);

    br2 = 4'h8;
    lit = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k >= 2 && k < 18 && segs2 != 0) lit++;
    end
    chk("br8_lit16", lit, 8);

    br2 = 4'hF;
    lit = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (segs2 != 0) lit++;
    end
    chk("br15_lit", lit, 36);

    value2 = 8'h05; blz2 = 1'b1; dpi2 = 2'b10;
    to_phase(0);
    dpa = 0; dpb = 0; lit = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k < 20 && dp2) dpa++;
      if (k >= 20 && dp2) dpb++;
      if (k >= 20 && segs2 != 0) lit++;
    end
    chk("dp_slot0", dpa, 0);
    chk("dp_slot1", dpb, 18);
    chk("blank_d1", lit, 0);

    to_phase(10);
    resetn = 1'b0;
    step();
    chk("mid_rst", {segs2, dp2, sel2, ft2}, 0);
    resetn = 1'b1;
    step();
    chk("restart_tick", ft2, 1);
    chk("restart_sel", sel2, 1);

    for (int v = 0; v < 7; v++) begin
      value4 = vecs[v].val;
      blz4   = vecs[v].blz;
      dpi4   = vecs[v].dp;
      n = 0;
      do begin step(); n++; end while (!ft4 && n < 200);
      chk("lz_tick", ft4, 1);
      for (int k = 1; k < 80; k++) begin
        step();
        if (k % 20 == 5) begin
          chk($sformatf("lz%0d_seg%0d", v, k / 20),
              segs4, vecs[v].segs[7*(k/20) +: 7]);
          chk($sformatf("lz%0d_dp%0d", v, k / 20),
              dp4, vecs[v].dp[k/20]);
          chk($sformatf("lz%0d_sel%0d", v, k / 20),
              sel4, 1 << (k / 20));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd_mux.md
Name: ssd_mux

Overview:
Parametrised time-multiplexed seven-segment display driver for N common-cathode digits. It is the successor to the fixed two-digit hex driver. It adds:
- a configurable digit count and slot length
- anti-ghosting guard time
- PWM brightness
- decimal points
- leading-zero blanking
- frame-coherent value snapshots

It sits between the stopwatch/controller datapath and the Pmod/board pins.

Parameters:
DIGITS, 2, number of multiplexed digits (1..8)
DIGIT_CYCLES, 1000, clk cycles each digit is selected (>= GUARD_CYCLES+16)
GUARD_CYCLES, 8, blank cycles at start of each digit slot (0 allowed)
BR_W, 4, brightness control width

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
value  in  4*DIGITS  hex nibbles; nibble i = digit i, digit 0 least significant
dp_in  in  DIGITS  decimal point request per digit
blank_lz  in  1  1 = blank leading zero digits
brightness  in  BR_W  segment duty control
ssd_segs  out  7  segments {A,B,C,D,E,F,G}, 1 = lit
ssd_dp  out  1  decimal point, 1 = lit
ssd_sel  out  DIGITS  one-hot digit select, 1 = selected
frame_tick  out  1  one-cycle pulse at start of each frame

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on `resetn`.
- All outputs are registered.
- Reset values: ssd_segs=0, ssd_dp=0, ssd_sel=0, frame_tick=0. Internal state: slot_cnt=0, idx=0, pwm_cnt=0, snapshot registers=0.
- Reset mid-operation: all outputs are inactive on the edge where resetn is sampled low. No partial digit is driven.
- Slot counter: slot_cnt counts 0..DIGIT_CYCLES-1, then wraps to 0 and idx advances. idx counts 0..DIGITS-1, then wraps to 0.
- Frame start: the cycle with slot_cnt=0 and idx=0.
- Snapshot: at frame start, value, dp_in, blank_lz and brightness are captured into snapshot registers. The whole frame displays snapshot data only, so mid-frame input changes are never visible before the next frame.
- First frame after reset: it starts on the first cycle with resetn high.
- frame_tick: asserted on the registered-output cycle matching frame start, one cycle wide.
- Select: ssd_sel = one-hot(idx), driven for the whole slot, guard included. It switches on the same edge as ssd_segs, with no skew between them.
- Guard: while slot_cnt < GUARD_CYCLES, ssd_segs=0 and ssd_dp=0.
- PWM: pwm_cnt is a free-running BR_W-bit counter that increments every cycle.
  - Outside the guard, the segments are lit iff pwm_cnt < snapshot brightness.
  - Exception: brightness all-ones means always lit.
  - brightness=0 means dark for the whole frame.
- Decode: snapshot nibble idx maps to standard hex glyphs via ssd_seg_decode:
  - 0=7'b1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Leading-zero blanking: when snapshot blank_lz=1, digit i (i>0) is blanked (ssd_segs=0) if nibble i and every more-significant nibble are 0.
  - Digit 0 is never blanked.
  - ssd_dp still follows dp_in on blanked digits, gated by guard and PWM.
- Latency: the displayed digit reflects state registered one cycle earlier. The decode path therefore has exactly one register stage from slot/idx state to the pins.
- Widths: slot_cnt is $clog2(DIGIT_CYCLES) bits and idx is $clog2(DIGITS) bits (minimum 1). The terminal compare is explicit at DIGIT_CYCLES-1, not a power-of-two wrap.

Decomposition:
- Package ssd_pkg holds:
  - the 16-entry glyph constants
  - a SEG_BLANK constant (7'b0)
  - a helper function clog2_min1
- One combinational sub-module, ssd_seg_decode (4-bit nibble -> 7-bit segments), instantiated once on the muxed nibble.
- Board wrappers for the two-digit Pmod connect the single DSP pin to ssd_sel[1].

Test Plan:
1. Reset: hold resetn=0 for 5 cycles with value=0xFF and brightness=15 -> all outputs 0. Release -> frame_tick pulses one cycle later and ssd_sel=2'b01.
2. Scan (DIGITS=2, DIGIT_CYCLES=20, GUARD=2, brightness=15), value=0x3A:
   - slot 0: segs 0 for 2 cycles, then 1110111 for 18 cycles with ssd_sel=01
   - slot 1: segs 0 for 2 cycles, then 1111001 with ssd_sel=10
   - frame_tick every 40 cycles.
3. Snapshot: change value 0x3A -> 0x12 at cycle 25 of a frame -> digit 1 still shows 3 in that frame. The next frame shows 2 then 1.
4. Leading zeros (DIGITS=4), value=0x0050, blank_lz=1 -> digits 3 and 2 segs=0, digit 1=1011011, digit 0=1111110. With blank_lz=0, digits 3 and 2 show 1111110.
5. Brightness, with value=0x88:
   - brightness=0 -> segs always 0
   - brightness=8 -> exactly 8 of every 16 non-guard cycles lit
   - brightness=15 -> all non-guard cycles lit.
6. Decimal point and reset: dp_in=2'b10 with digit 1 blanked -> ssd_dp=1 only in slot 1 after the guard. Assert resetn=0 mid-slot -> the next edge gives all outputs 0 and scanning restarts at idx=0.
